// File: rtl/pool_wr_serializer.sv
// Splits 64-bit pooled words into two 32-bit SRAM writes (low half first) behind a small FIFO.
// Optional feature: define POOL_WR_OVF_CNT_EN to count dropped pool_valid strobes on ovf_cnt.
module pool_wr_serializer #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  total_words,
    input  logic              pool_valid,
    input  logic [63:0]       pool_data,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [7:0]        ovf_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    state_e            state_q, state_d;
    logic [63:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d, total_q, total_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic              full, xfer, pop, push, drop, last;
    logic [CNT_W:0]    word_cnt_inc;
    logic [63:0]       head;

    assign full         = count_q == (PTR_W+1)'(FIFO_DEPTH);
    assign xfer         = (state_q != StIdle) && mem_ready;
    assign pop          = xfer && (state_q == StHi);
    // A pop in the same cycle frees the slot the incoming word needs.
    assign push         = pool_valid && busy_q && (!full || pop);
    assign drop         = pool_valid && busy_q && full && !pop;
    assign word_cnt_inc = {1'b0, word_cnt_q} + (CNT_W+1)'(2);
    assign last         = word_cnt_inc >= {1'b0, total_q};
    assign head         = fifo_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        total_d    = total_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        if (start) begin
            state_d    = StIdle;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            addr_d     = base_addr;
            word_cnt_d = '0;
            total_d    = total_words;
            busy_d     = total_words != '0;
            done_d     = total_words == '0;
            ovf_d      = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) ovf_d = 1'b1;
            if (xfer) addr_d = addr_q + ADDR_W'(1);

            case (state_q)
                StIdle: begin
                    // Looking at push as well gives one-cycle latency from an empty FIFO.
                    if (busy_q && (count_q != '0 || push)) state_d = StLo;
                end
                StLo: begin
                    if (xfer) state_d = StHi;
                end
                StHi: begin
                    if (xfer) begin
                        word_cnt_d = word_cnt_inc[CNT_W-1:0];
                        if (last) begin
                            state_d  = StIdle;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            count_d  = '0;
                        end else if (count_d != '0) begin
                            state_d = StLo;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            total_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            total_q    <= total_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: mem_wdata is forced to zero whenever the FSM is idle.
    always_ff @(posedge clk) begin
        if (push && !start && !rst) fifo_q[wr_ptr_q] <= pool_data;
    end

    always_comb begin
        mem_wdata = '0;
        if (state_q == StLo)      mem_wdata = head[31:0];
        else if (state_q == StHi) mem_wdata = head[63:32];
    end

    assign mem_wen  = state_q != StIdle;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

`ifdef POOL_WR_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            ovf_cnt_q <= '0;
        end else if (drop && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pool_wr_serializer.sv
// Scoreboard bench for pool_wr_serializer: expected writes are queued with the stimulus
// and compared against the transfers the monitor observes.
module tb_pool_wr_serializer;

    logic        clk = 1'b0;
    logic        rst, start, pool_valid, mem_ready;
    logic [11:0] base_addr, mem_addr;
    logic [11:0] total_words;
    logic [63:0] pool_data;
    logic        mem_wen, busy, done, ovf;
    logic [31:0] mem_wdata;
    logic [7:0]  ovf_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [43:0] exp_q[$];
    logic [43:0] obs_q[$];

`ifdef POOL_WR_OVF_CNT_EN
    localparam logic [7:0] OVF_CNT_EXP = 8'd2;
`else
    localparam logic [7:0] OVF_CNT_EXP = 8'd0;
`endif

    pool_wr_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .total_words (total_words),
        .pool_valid  (pool_valid),
        .pool_data   (pool_data),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Inputs only change 1 time unit after posedge, so a handshake seen at negedge
    // is the transfer taken on the following posedge.
    always @(negedge clk) begin
        if (mem_wen === 1'b1 && mem_ready === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] base, input logic [11:0] total);
        start       = 1'b1;
        base_addr   = base;
        total_words = total;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [11:0] addr, input logic [63:0] w);
        exp_q.push_back({addr, w[31:0]});
        exp_q.push_back({addr + 12'd1, w[63:32]});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pool_valid = 1'b0; mem_ready = 1'b0;
        base_addr = '0; total_words = '0; pool_data = '0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({mem_wen, busy, done, ovf} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0000", {mem_wen, busy, done, ovf});
        end
        vectors++;
        if ({mem_addr, mem_wdata, ovf_cnt} !== 52'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, ovf_cnt);
        end
    endtask

    task automatic test_basic();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b1;
        do_start(12'h010, 12'd4);
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_start busy/done got %b want 10", {busy, done});
        end
        pool_valid = 1'b1; pool_data = 64'h8877665544332211;
        push_word(12'h010, pool_data);
        tick();
        vectors++;
        if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 12'h010, 32'h44332211}) begin
            miscompares++;
            $display("FAIL basic_latency got %b/%h/%h want 1/010/44332211",
                     mem_wen, mem_addr, mem_wdata);
        end
        pool_data = 64'hFFEEDDCCBBAA9988;
        push_word(12'h012, pool_data);
        tick();
        pool_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 4 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_early got %b want 0", done);
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_done got busy/done %b want 01", {busy, done});
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL basic_write got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        do_start(12'h020, 12'd2);
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_start busy/done got %b want 10", {busy, done});
        end
        pool_valid = 1'b1; pool_data = 64'h0123456789ABCDEF;
        push_word(12'h020, pool_data);
        tick();
        pool_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 12'h020, 32'h89ABCDEF}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got %b/%h/%h want 1/020/89abcdef",
                         i, mem_wen, mem_addr, mem_wdata);
            end
            tick();
        end
        mem_ready = 1'b1;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done got %b want 1", done);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stall_write got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        do_start(12'h030, 12'd8);
        pool_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pool_data = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
            if (i < 4) push_word(12'h030 + 12'(2 * i), pool_data);
            tick();
        end
        pool_valid = 1'b0;
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag got %b want 1", ovf);
        end
        vectors++;
        if (ovf_cnt !== OVF_CNT_EXP) begin
            miscompares++;
            $display("FAIL ovf_cnt got %0d want %0d", ovf_cnt, OVF_CNT_EXP);
        end
        mem_ready = 1'b1;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        tick(); tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL ovf_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ovf_write got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b1;
        do_start(12'hFFE, 12'd4);
        vectors++;
        if ({ovf, ovf_cnt} !== 9'd0) begin
            miscompares++;
            $display("FAIL wrap_ovf_clear got %b/%0d want 0/0", ovf, ovf_cnt);
        end
        pool_valid = 1'b1; pool_data = 64'h2222_2222_1111_1111;
        push_word(12'hFFE, pool_data);
        tick();
        pool_data = 64'h4444_4444_3333_3333;
        push_word(12'h000, pool_data);
        tick();
        pool_valid = 1'b0;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_write got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        do_start(12'h040, 12'd10);
        pool_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pool_data = {32'hD000_0000 | 32'(i), 32'hC000_0000 | 32'(i)};
            push_word(12'h040 + 12'(2 * i), pool_data);
            tick();
        end
        // FIFO full: one LO transfer moves the FSM to HI without a pop.
        pool_valid = 1'b0; mem_ready = 1'b1;
        tick();
        pool_valid = 1'b1;
        pool_data  = 64'hD000_0004_C000_0004;
        push_word(12'h048, pool_data);
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop_ovf got %b want 0", ovf);
        end
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL pushpop_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL pushpop_write got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_zero();
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b1;
        do_start(12'h080, 12'd0);
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_done busy/done got %b want 01", {busy, done});
        end
        pool_valid = 1'b1; pool_data = 64'h5555_5555_6666_6666;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (mem_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_wen[%0d] got %b want 0", i, mem_wen);
            end
        end
        pool_valid = 1'b0;
        vectors++;
        if (ovf !== 1'b0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_idle ovf/writes got %b/%0d want 0/0", ovf, obs_q.size());
        end
    endtask

    task automatic test_restart();
        logic [43:0] e, o;
        int n;
        obs_q.delete(); exp_q.delete();
        mem_ready = 1'b0;
        do_start(12'h050, 12'd4);
        pool_valid = 1'b1; pool_data = 64'h7777_7777_6666_6666;
        exp_q.push_back({12'h050, 32'h6666_6666});
        tick();
        pool_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        vectors++;
        if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 12'h051, 32'h7777_7777}) begin
            miscompares++;
            $display("FAIL restart_hi got %b/%h/%h want 1/051/77777777",
                     mem_wen, mem_addr, mem_wdata);
        end
        do_start(12'h100, 12'd2);
        vectors++;
        if ({mem_wen, busy, done} !== 3'b010) begin
            miscompares++;
            $display("FAIL restart_drop wen/busy/done got %b want 010", {mem_wen, busy, done});
        end
        pool_valid = 1'b1; pool_data = 64'h9999_9999_8888_8888;
        push_word(12'h100, pool_data);
        mem_ready = 1'b1;
        tick();
        pool_valid = 1'b0;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL restart_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL restart_write got %h want %h", o, e);
            end
        end
        // Reset in the middle of a stalled write.
        mem_ready = 1'b0;
        do_start(12'h200, 12'd4);
        pool_valid = 1'b1; pool_data = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (mem_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_wen got %b want 1", mem_wen);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({mem_wen, busy, done, ovf, mem_addr, mem_wdata, ovf_cnt} !== 56'd0) begin
            miscompares++;
            $display("FAIL rst_mid got %b%b%b%b/%h/%h/%h want all 0",
                     mem_wen, busy, done, ovf, mem_addr, mem_wdata, ovf_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_wrap();
        test_same_cycle();
        test_zero();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
